max_log_map_siso: RTL and testbench
===================================

// Module: max_log_map_siso
// PURPOSE
//  Parametrised Max-Log-MAP soft-in/soft-out decoder for one constituent RSC code (4-state, g=(7,5) octal).
//  Accepts one block of K symbol triples (sys, parity, a-priori LLR) over a valid/ready stream.
//  Forward alpha recursion runs during load. Backward beta/LLR recursion runs after load.
//  Streams extrinsic LLRs and hard decisions out in natural order. Sits after the serial demux, one instance per constituent decoder.
// PARAMETERS
//  K      24  block length in trellis steps (>=2)
//  W      8   LLR width, signed two's complement (in and out)
//  ACC_W  12  path-metric width, signed; ACC_W >= W+4
//  TERM   0   1: trellis terminated in state 0 (beta_K = {0,NEG,NEG,NEG}); 0: open (beta_K all 0)
// PORTS
//  clk        in   1      clock, rising edge
//  rst_n      in   1      asynchronous reset, active low
//  in_valid   in   1      input triple valid
//  in_ready   out  1      decoder accepting input (LOAD state)
//  in_sys     in   W      systematic LLR Ls
//  in_par     in   W      parity LLR Lp
//  in_apr     in   W      a-priori LLR La
//  out_valid  out  1      output beat valid
//  out_ready  in   1      downstream accepts output
//  out_ext    out  W      extrinsic LLR Le, saturated
//  out_hard   out  1      hard decision, 1 when Lapp > 0
//  out_last   out  1      high on beat K-1
//  busy       out  1      high in BWD or OUT
// BEHAVIOUR
//  LLR convention: positive means bit = 1.
//  Trellis: state s = {d1,d2}; a = u^d1^d2; p = a^d2; next = {a,d1}.
//  Branch metric gamma(u,p) = u*(Ls+La) + p*Lp. Inputs are sign-extended to ACC_W.
//  NEG = -2^(ACC_W-2). alpha_0 = {0,NEG,NEG,NEG}.
//  Recursion: alpha_k+1[s'] = max over incoming branches of (alpha_k[s] + gamma).
//  Normalisation: after each step, subtract new state-0 metric from all four (alpha and beta alike).
//  FSM LOAD -> BWD -> OUT -> LOAD. Reset enters LOAD.
//  LOAD: in_ready=1. On in_valid&&in_ready:
//   - store triple at index k
//   - store alpha_k; register alpha_k+1
//   - k++
//   in_valid low stalls with no state change. After beat K-1 is accepted, next cycle is BWD and in_ready=0.
//  BWD: exactly K cycles, k = K-1 down to 0, one step per cycle.
//   Per step: beta_k from beta_k+1.
//   Lapp = max_{u=1}(alpha_k+gamma+beta_k+1) - max_{u=0}(alpha_k+gamma+beta_k+1).
//   Le = Lapp - Ls - La, saturated to [-(2^(W-1)-1), +(2^(W-1)-1)]; -2^(W-1) is never produced.
//   Store Le and hard bit at index k.
//  OUT: beats j = 0..K-1. out_ext/out_hard/out_last come from registers.
//   - Beat advances only on out_valid&&out_ready.
//   - Data is held stable while out_valid && !out_ready.
//   - After beat K-1 handshakes: out_valid=0 and state=LOAD next cycle (in_ready=1).
//  No overlap between blocks: in_ready=0 throughout BWD and OUT.
//  Reset (async, any state):
//   - in_ready=0 while rst_n low, then 1 in first cycle after release
//   - out_valid=0, out_ext=0, out_hard=0, out_last=0, busy=0
//   - counters 0, stored metrics invalid; partial block discarded
//  Latency: last input accept -> first out_valid = K+1 cycles.
//  Metric arithmetic wraps-free by normalisation. The ACC_W >= W+4 bound is mandatory, not checked in RTL.
// TESTING (K=8, W=8, ACC_W=12, TERM=0 unless stated; compare against bit-accurate C model)
//  1. All-zero codeword, Ls=Lp=-20, La=0 x8 -> out_hard=0 all 8 beats; out_ext <=0; out_last only on beat 7.
//  2. u=10110010 encoded, LLRs +/-30, La=0, TERM=1 with 2 tail steps (K=10) -> out_hard matches u and tail; out_ext bit-exact vs model.
//  3. Ls=Lp=La=+127 all beats -> out_ext in [-127,+127], never -128; out_hard=1.
//  4. in_valid toggled 1-0-1 during LOAD, out_ready low 3 cycles at beat 4
//     -> identical out_ext stream to unstalled run; data held stable while stalled.
//  5. rst_n pulsed low after 3 accepted beats, then full block sent -> no out_valid before 9 cycles post-load; result equals clean run.
//  6. Back-to-back blocks -> in_ready low from cycle after beat 7 until beat 7 out handshake; first out_valid 9 cycles after last input.

Source files
------------

// File: rtl/max_log_map_siso.sv
// Max-Log-MAP soft-in/soft-out decoder for one 4-state (7,5) RSC constituent code.
// Alpha recursion runs while the block loads; beta/LLR recursion follows; results stream out in natural order.
module max_log_map_siso #(
    parameter int K     = 24,
    parameter int W     = 8,
    parameter int ACC_W = 12,
    parameter int TERM  = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_sys,
    input  logic [W-1:0] in_par,
    input  logic [W-1:0] in_apr,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_ext,
    output logic         out_hard,
    output logic         out_last,
    output logic         busy
);
    // Sums of alpha+gamma+beta need headroom beyond the stored metric width.
    localparam int SW = ACC_W + 3;
    localparam int KW = $clog2(K);

    typedef logic signed [ACC_W-1:0] metric_t;
    typedef logic signed [SW-1:0]    wide_t;

    localparam logic [KW-1:0] K_LAST = KW'(K - 1);
    localparam metric_t       ZERO   = '0;
    localparam metric_t       NEG    = {2'b11, {(ACC_W-2){1'b0}}};
    localparam wide_t         LE_MAX = wide_t'((1 << (W - 1)) - 1);

    localparam logic [1:0] S_LOAD = 2'd0;
    localparam logic [1:0] S_BWD  = 2'd1;
    localparam logic [1:0] S_OUT  = 2'd2;

    logic [1:0]    state;
    logic [KW-1:0] k_q;
    logic [KW-1:0] k_inc;
    logic          in_ready_q;
    logic          out_valid_q;
    logic [W-1:0]  out_ext_q;
    logic          out_hard_q;
    logic          out_last_q;
    metric_t       alpha_q [4];
    metric_t       beta_q  [4];
    metric_t       alpha_nx [4];
    metric_t       beta_nx  [4];
    logic [W-1:0]  ext_nx;
    logic          hard_nx;
    logic          accept;

    logic [W-1:0]  sys_mem  [K];
    logic [W-1:0]  par_mem  [K];
    logic [W-1:0]  apr_mem  [K];
    metric_t       alpha_mem [K][4];
    logic [W-1:0]  ext_mem  [K];
    logic          hard_mem [K];

    function automatic wide_t sext(input logic [W-1:0] x);
        return {{(SW-W){x[W-1]}}, x};
    endfunction

    function automatic wide_t gamma(input logic u, input logic p, input wide_t lsa, input wide_t lp);
        wide_t g;
        g = '0;
        if (u) g = g + lsa;
        if (p) g = g + lp;
        return g;
    endfunction

    assign accept = (state == S_LOAD) && in_valid && in_ready_q;
    assign k_inc  = k_q + 1'b1;

    // Forward step: state {a,d1} is reached from {d1,d2} for both values of d2.
    always_comb begin : alpha_step
        wide_t      best [4];
        wide_t      cand;
        wide_t      lsa;
        wide_t      lp;
        logic [1:0] sp;
        logic [1:0] s;
        logic       u;
        logic       p;
        // NOTE: every combinational variable gets a default before any conditional write, so no latch is inferred.
        lsa = sext(in_sys) + sext(in_apr);
        lp  = sext(in_par);
        for (int i = 0; i < 4; i++) begin
            sp      = 2'(i);
            best[i] = '0;
            for (int d2 = 0; d2 < 2; d2++) begin
                s    = {sp[0], 1'(d2)};
                u    = sp[1] ^ sp[0] ^ 1'(d2);
                p    = sp[1] ^ 1'(d2);
                cand = wide_t'(alpha_q[s]) + gamma(u, p, lsa, lp);
                if (d2 == 0 || cand > best[i]) best[i] = cand;
            end
        end
        for (int i = 0; i < 4; i++) alpha_nx[i] = metric_t'(best[i] - best[0]);
    end

    // Backward step and a-posteriori LLR for trellis step k_q.
    always_comb begin : beta_step
        wide_t      bbest [4];
        wide_t      cand;
        wide_t      m0;
        wide_t      m1;
        wide_t      lsa;
        wide_t      lp;
        wide_t      lapp;
        wide_t      le;
        wide_t      le_sat;
        logic [1:0] s;
        logic [1:0] nx;
        logic       u;
        logic       a;
        logic       p;
        lsa = sext(sys_mem[k_q]) + sext(apr_mem[k_q]);
        lp  = sext(par_mem[k_q]);
        m0  = '0;
        m1  = '0;
        for (int i = 0; i < 4; i++) begin
            s        = 2'(i);
            bbest[i] = '0;
            for (int j = 0; j < 2; j++) begin
                u    = 1'(j);
                a    = u ^ s[1] ^ s[0];
                p    = a ^ s[0];
                nx   = {a, s[1]};
                cand = gamma(u, p, lsa, lp) + wide_t'(beta_q[nx]);
                if (j == 0 || cand > bbest[i]) bbest[i] = cand;
                cand = cand + wide_t'(alpha_mem[k_q][s]);
                if (u) begin
                    if (i == 0 || cand > m1) m1 = cand;
                end else begin
                    if (i == 0 || cand > m0) m0 = cand;
                end
            end
        end
        for (int i = 0; i < 4; i++) beta_nx[i] = metric_t'(bbest[i] - bbest[0]);
        lapp = m1 - m0;
        le   = lapp - lsa;
        if (le > LE_MAX)       le_sat = LE_MAX;
        else if (le < -LE_MAX) le_sat = -LE_MAX;
        else                   le_sat = le;
        ext_nx  = W'(le_sat);
        hard_nx = (lapp > 0);
    end

    // NOTE: block storage carries no reset; state and k_q alone decide which entries are meaningful.
    always_ff @(posedge clk) begin
        if (accept) begin
            sys_mem[k_q] <= in_sys;
            par_mem[k_q] <= in_par;
            apr_mem[k_q] <= in_apr;
            for (int i = 0; i < 4; i++) alpha_mem[k_q][i] <= alpha_q[i];
        end
        if (state == S_BWD) begin
            ext_mem[k_q]  <= ext_nx;
            hard_mem[k_q] <= hard_nx;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_LOAD;
            k_q         <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_ext_q   <= '0;
            out_hard_q  <= 1'b0;
            out_last_q  <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                alpha_q[i] <= (i == 0) ? ZERO : NEG;
                beta_q[i]  <= ZERO;
            end
        end else begin
            case (state)
                S_LOAD: begin
                    in_ready_q <= 1'b1;
                    if (accept) begin
                        for (int i = 0; i < 4; i++) alpha_q[i] <= alpha_nx[i];
                        if (k_q == K_LAST) begin
                            state      <= S_BWD;
                            in_ready_q <= 1'b0;
                            for (int i = 0; i < 4; i++)
                                beta_q[i] <= (TERM != 0 && i != 0) ? NEG : ZERO;
                        end else begin
                            k_q <= k_inc;
                        end
                    end
                end
                S_BWD: begin
                    for (int i = 0; i < 4; i++) beta_q[i] <= beta_nx[i];
                    if (k_q == '0) begin
                        // Beat 0 is produced on the final backward step, so bypass the memory.
                        state       <= S_OUT;
                        out_valid_q <= 1'b1;
                        out_ext_q   <= ext_nx;
                        out_hard_q  <= hard_nx;
                        out_last_q  <= 1'b0;
                    end else begin
                        k_q <= k_q - 1'b1;
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        if (k_q == K_LAST) begin
                            state       <= S_LOAD;
                            k_q         <= '0;
                            in_ready_q  <= 1'b1;
                            out_valid_q <= 1'b0;
                            out_ext_q   <= '0;
                            out_hard_q  <= 1'b0;
                            out_last_q  <= 1'b0;
                            for (int i = 0; i < 4; i++) alpha_q[i] <= (i == 0) ? ZERO : NEG;
                        end else begin
                            k_q        <= k_inc;
                            out_ext_q  <= ext_mem[k_inc];
                            out_hard_q <= hard_mem[k_inc];
                            out_last_q <= (k_inc == K_LAST);
                        end
                    end
                end
                default: state <= S_LOAD;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_ext   = out_ext_q;
    assign out_hard  = out_hard_q;
    assign out_last  = out_last_q;
    assign busy      = (state == S_BWD) || (state == S_OUT);

endmodule

// File: tb/tb_max_log_map_siso.sv
// Scoreboard bench for max_log_map_siso: an unnormalised integer Max-Log-MAP model predicts every output beat.
// Also tracks handshake/busy timing, output hold under backpressure and reset behaviour.
module tb_max_log_map_siso;
    localparam int K     = 8;
    localparam int W     = 8;
    localparam int ACC_W = 12;
    localparam int TERM  = 0;
    localparam int NEG   = -(1 << (ACC_W - 2));
    localparam int LMAX  = (1 << (W - 1)) - 1;
    localparam int LOW   = -(1 << 30);

    logic         clk       = 1'b0;
    logic         rst_n     = 1'b0;
    logic         in_valid  = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_sys    = '0;
    logic [W-1:0] in_par    = '0;
    logic [W-1:0] in_apr    = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_ext;
    logic         out_hard;
    logic         out_last;
    logic         busy;

    always #5 clk = ~clk;

    max_log_map_siso #(.K(K), .W(W), .ACC_W(ACC_W), .TERM(TERM)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_sys   (in_sys),
        .in_par   (in_par),
        .in_apr   (in_apr),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_ext  (out_ext),
        .out_hard (out_hard),
        .out_last (out_last),
        .busy     (busy)
    );

    typedef struct {
        int ext;
        bit hard;
        bit last;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;
    int   blk_s [K];
    int   blk_p [K];
    int   blk_a [K];
    int   ready_pct   = 100;
    int   stall_at    = -1;
    int   stall_cnt   = 0;
    int   beat_out    = 0;
    bit   in_flight   = 1'b0;
    int   beats_in    = 0;
    int   last_acc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic abort(input string why);
        miscompares++;
        $display("FAIL %s: timed out (t=%0t)", why, $time);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $fatal(1, "bench aborted");
    endtask

    function automatic void trellis(input int s, input int u, output int nxt, output int p);
        int d1, d2, a;
        d1  = (s >> 1) & 1;
        d2  = s & 1;
        a   = u ^ d1 ^ d2;
        p   = a ^ d2;
        nxt = a * 2 + d1;
    endfunction

    // Plain max-sum forward/backward over the whole block; offsets cancel in Lapp, so no normalisation.
    task automatic run_model();
        int   alpha [K+1][4];
        int   beta  [K+1][4];
        int   nxt, p, g, cand, m0, m1, lapp, le;
        exp_t e;
        exp_t res [K];
        for (int s = 0; s < 4; s++) begin
            alpha[0][s] = (s == 0) ? 0 : NEG;
            beta[K][s]  = (TERM != 0 && s != 0) ? NEG : 0;
        end
        for (int k = 0; k < K; k++) begin
            for (int s = 0; s < 4; s++) alpha[k+1][s] = LOW;
            for (int s = 0; s < 4; s++)
                for (int u = 0; u < 2; u++) begin
                    trellis(s, u, nxt, p);
                    g = u * (blk_s[k] + blk_a[k]) + p * blk_p[k];
                    if (alpha[k][s] + g > alpha[k+1][nxt]) alpha[k+1][nxt] = alpha[k][s] + g;
                end
        end
        for (int k = K - 1; k >= 0; k--) begin
            m0 = LOW;
            m1 = LOW;
            for (int s = 0; s < 4; s++) begin
                beta[k][s] = LOW;
                for (int u = 0; u < 2; u++) begin
                    trellis(s, u, nxt, p);
                    g    = u * (blk_s[k] + blk_a[k]) + p * blk_p[k];
                    cand = g + beta[k+1][nxt];
                    if (cand > beta[k][s]) beta[k][s] = cand;
                    cand = cand + alpha[k][s];
                    if (u == 1) begin
                        if (cand > m1) m1 = cand;
                    end else begin
                        if (cand > m0) m0 = cand;
                    end
                end
            end
            lapp = m1 - m0;
            le   = lapp - blk_s[k] - blk_a[k];
            if (le > LMAX)  le = LMAX;
            if (le < -LMAX) le = -LMAX;
            e.ext  = le;
            e.hard = (lapp > 0);
            e.last = (k == K - 1);
            res[k] = e;
        end
        for (int k = 0; k < K; k++) sb.push_back(res[k]);
    endtask

    task automatic fill_const(input int s, input int p, input int a);
        for (int k = 0; k < K; k++) begin
            blk_s[k] = s;
            blk_p[k] = p;
            blk_a[k] = a;
        end
    endtask

    task automatic fill_code(input bit u_bits [K], input int amp);
        int s, nxt, p;
        s = 0;
        for (int k = 0; k < K; k++) begin
            trellis(s, int'(u_bits[k]), nxt, p);
            blk_s[k] = u_bits[k] ? amp : -amp;
            blk_p[k] = (p != 0) ? amp : -amp;
            blk_a[k] = 0;
            s = nxt;
        end
    endtask

    task automatic fill_rand();
        for (int k = 0; k < K; k++) begin
            blk_s[k] = int'($urandom_range(255)) - 128;
            blk_p[k] = int'($urandom_range(255)) - 128;
            blk_a[k] = int'($urandom_range(63)) - 32;
        end
    endtask

    task automatic send_block(input int gap_pct, input int nbeats);
        int t;
        for (int k = 0; k < nbeats; k++) begin
            while (int'($urandom_range(99)) < gap_pct) begin
                in_valid = 1'b0;
                @(posedge clk);
                #1;
            end
            in_valid = 1'b1;
            in_sys   = W'(blk_s[k]);
            in_par   = W'(blk_p[k]);
            in_apr   = W'(blk_a[k]);
            t = 0;
            @(negedge clk);
            while (!in_ready) begin
                t++;
                if (t > 500) abort("in_ready_wait");
                @(negedge clk);
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic issue(input int gap_pct);
        run_model();
        send_block(gap_pct, K);
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (sb.size() != 0 || in_flight) begin
            @(negedge clk);
            t++;
            if (t > 3000) abort("drain_wait");
        end
    endtask

    // Backpressure: random out_ready, plus an optional 3-cycle stall on a chosen beat.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (stall_at >= 0 && beat_out == stall_at && out_valid && stall_cnt < 3) begin
                out_ready = 1'b0;
                stall_cnt++;
            end else begin
                out_ready = (int'($urandom_range(99)) < ready_pct);
            end
        end
    end

    // Monitor: sampled on the falling edge, between active edges.
    initial begin
        exp_t         e;
        bit           hold;
        logic [W-1:0] h_ext;
        logic         h_hard;
        logic         h_last;
        hold = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                check("reset_outputs", {in_ready, out_valid, busy, out_hard, out_last, out_ext}, 0);
                in_flight = 1'b0;
                beats_in  = 0;
                beat_out  = 0;
                hold      = 1'b0;
            end else begin
                check("busy", busy, in_flight);
                check("in_ready", in_ready, !in_flight);
                check("out_valid_timing", out_valid, in_flight && (cyc - last_acc >= K + 1));
                if (hold)
                    check("hold_stable", {out_valid, out_ext, out_hard, out_last},
                          {1'b1, h_ext, h_hard, h_last});
                hold = 1'b0;
                if (out_valid) begin
                    if (out_ready) begin
                        if (sb.size() == 0) begin
                            check("unexpected_output", 1, 0);
                        end else begin
                            e = sb.pop_front();
                            check("out_ext", $signed(out_ext), e.ext);
                            check("out_hard", out_hard, e.hard);
                            check("out_last", out_last, e.last);
                        end
                        if (beat_out == K - 1) begin
                            in_flight = 1'b0;
                            beat_out  = 0;
                        end else begin
                            beat_out++;
                        end
                    end else begin
                        hold   = 1'b1;
                        h_ext  = out_ext;
                        h_hard = out_hard;
                        h_last = out_last;
                    end
                end
                if (in_valid && in_ready) begin
                    beats_in++;
                    if (beats_in == K) begin
                        beats_in  = 0;
                        in_flight = 1'b1;
                        last_acc  = cyc;
                    end
                end
            end
        end
    end

    initial begin
        bit u_bits [K];
        u_bits = '{1, 0, 1, 1, 0, 0, 1, 0};
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        fill_const(-20, -20, 0);
        issue(0);
        fill_code(u_bits, 30);
        issue(0);
        fill_const(127, 127, 127);
        issue(0);
        fill_const(-128, -128, -128);
        issue(0);
        wait_drain();

        // Same block clean, then with input gaps and a 3-cycle stall on beat 4.
        fill_rand();
        issue(0);
        wait_drain();
        stall_at  = 4;
        stall_cnt = 0;
        issue(40);
        wait_drain();
        stall_at = -1;

        // Partial block discarded by reset, then the full block.
        fill_rand();
        send_block(0, 3);
        @(negedge clk);
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        issue(0);
        wait_drain();

        // Back-to-back random blocks under random backpressure.
        ready_pct = 60;
        for (int b = 0; b < 10; b++) begin
            fill_rand();
            issue(30);
        end
        wait_drain();
        ready_pct = 100;
        repeat (4) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
